// File: rtl/cpu_pkg.sv
// Shared definitions for the multi-cycle control sequencer: opcodes, ALU codes,
// sequencer states and instruction classes.
package cpu_pkg;

    localparam logic [4:0] OP_LD   = 5'b00000;
    localparam logic [4:0] OP_LDI  = 5'b00001;
    localparam logic [4:0] OP_ST   = 5'b00010;
    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b01010;
    localparam logic [4:0] OP_OR   = 5'b01011;
    localparam logic [4:0] OP_ADDI = 5'b01100;
    localparam logic [4:0] OP_ANDI = 5'b01101;
    localparam logic [4:0] OP_ORI  = 5'b01110;
    localparam logic [4:0] OP_MUL  = 5'b01111;
    localparam logic [4:0] OP_DIV  = 5'b10000;
    localparam logic [4:0] OP_BR   = 5'b10011;
    localparam logic [4:0] OP_MFHI = 5'b11000;
    localparam logic [4:0] OP_MFLO = 5'b11001;
    localparam logic [4:0] OP_NOP  = 5'b11010;
    localparam logic [4:0] OP_HALT = 5'b11011;

    localparam logic [3:0] ALU_ADD = 4'd0;
    localparam logic [3:0] ALU_SUB = 4'd1;
    localparam logic [3:0] ALU_AND = 4'd2;
    localparam logic [3:0] ALU_OR  = 4'd3;
    localparam logic [3:0] ALU_MUL = 4'd9;
    localparam logic [3:0] ALU_DIV = 4'd10;

    typedef enum logic [3:0] {
        ST_RESET, ST_T0, ST_T1, ST_T2, ST_T3, ST_T4, ST_T5, ST_T6, ST_T7, ST_HALT
    } state_e;

    typedef enum logic [3:0] {
        CL_ALU, CL_IMM, CL_LDI, CL_LD, CL_ST, CL_MULDIV, CL_MFHI, CL_MFLO,
        CL_BR, CL_NOP, CL_HALT, CL_ILLEGAL
    } op_class_e;

    function automatic state_e next_step(input state_e s);
        case (s)
            ST_T0:   return ST_T1;
            ST_T1:   return ST_T2;
            ST_T2:   return ST_T3;
            ST_T3:   return ST_T4;
            ST_T4:   return ST_T5;
            ST_T5:   return ST_T6;
            ST_T6:   return ST_T7;
            default: return ST_T0;
        endcase
    endfunction

endpackage

// File: rtl/op_decode.sv
// Combinational opcode decoder: maps a 5-bit opcode to its instruction class
// and the ALU operation used by its execute sequence.
module op_decode
    import cpu_pkg::*;
(
    input  logic [4:0] opcode,
    output op_class_e  op_class,
    output logic [3:0] alu_code
);

    always_comb begin
        op_class = CL_ILLEGAL;
        alu_code = ALU_ADD;
        case (opcode)
            OP_LD:   op_class = CL_LD;
            OP_LDI:  op_class = CL_LDI;
            OP_ST:   op_class = CL_ST;
            OP_ADD:  op_class = CL_ALU;
            OP_SUB:  begin op_class = CL_ALU; alu_code = ALU_SUB; end
            OP_AND:  begin op_class = CL_ALU; alu_code = ALU_AND; end
            OP_OR:   begin op_class = CL_ALU; alu_code = ALU_OR;  end
            OP_ADDI: op_class = CL_IMM;
            OP_ANDI: begin op_class = CL_IMM; alu_code = ALU_AND; end
            OP_ORI:  begin op_class = CL_IMM; alu_code = ALU_OR;  end
            OP_MUL:  begin op_class = CL_MULDIV; alu_code = ALU_MUL; end
            OP_DIV:  begin op_class = CL_MULDIV; alu_code = ALU_DIV; end
            OP_BR:   op_class = CL_BR;
            OP_MFHI: op_class = CL_MFHI;
            OP_MFLO: op_class = CL_MFLO;
            OP_NOP:  op_class = CL_NOP;
            OP_HALT: op_class = CL_HALT;
            default: ;
        endcase
    end

endmodule

// File: rtl/control_sequencer.sv
// Multi-cycle CPU control unit: fetch plus per-class execute sequences, one
// control step per clock, with sticky stop request and HALT.
module control_sequencer
    import cpu_pkg::*;
#(
    parameter int IR_W  = 32,
    parameter int SEL_W = 4
) (
    input  logic             clock,
    input  logic             clear,
    input  logic [IR_W-1:0]  ir,
    input  logic             con_ff,
    input  logic             stop,
    output logic             PCout,
    output logic             PCin,
    output logic             IncPC,
    output logic             IRin,
    output logic             MARin,
    output logic             MDRin,
    output logic             MDRout,
    output logic             Read,
    output logic             Write,
    output logic             Gra,
    output logic             Grb,
    output logic             Grc,
    output logic             Rin,
    output logic             Rout,
    output logic             BAout,
    output logic             Yin,
    output logic             Zin,
    output logic             Zhighout,
    output logic             Zlowout,
    output logic             Cout,
    output logic             CONin,
    output logic             HIin,
    output logic             HIout,
    output logic             LOin,
    output logic             LOout,
    output logic [SEL_W-1:0] ALUselect,
    output logic             run,
    output logic             illegal
);

    state_e     state;
    logic [4:0] opcode_q;
    logic [4:0] opcode;
    logic       stop_flag;
    logic       last_step;
    op_class_e  op_class;
    logic [3:0] alu_code;
    logic       unused_ir;

    // The new instruction is only visible on ir during T3; later steps use the latched copy.
    assign opcode    = (state == ST_T3) ? ir[31:27] : opcode_q;
    assign unused_ir = ^ir;

    op_decode u_decode (
        .opcode   (opcode),
        .op_class (op_class),
        .alu_code (alu_code)
    );

    always_comb begin
        last_step = 1'b0;
        case (state)
            ST_T3:   last_step = op_class inside {CL_NOP, CL_MFHI, CL_MFLO, CL_ILLEGAL};
            ST_T5:   last_step = op_class inside {CL_ALU, CL_IMM, CL_LDI};
            ST_T6:   last_step = op_class inside {CL_MULDIV, CL_BR};
            ST_T7:   last_step = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!clear) begin
            state     <= ST_RESET;
            opcode_q  <= '0;
            stop_flag <= 1'b0;
        end else begin
            stop_flag <= stop_flag | stop;
            if (state == ST_T3)
                opcode_q <= ir[31:27];
            case (state)
                ST_RESET: state <= ST_T0;
                ST_HALT:  state <= ST_HALT;
                default: begin
                    if ((state == ST_T3 && op_class == CL_HALT) ||
                        (last_step && (stop_flag || stop))) begin
                        state     <= ST_HALT;
                        stop_flag <= 1'b0;
                    end else if (last_step) begin
                        state <= ST_T0;
                    end else begin
                        state <= next_step(state);
                    end
                end
            endcase
        end
    end

    always_comb begin
        {PCout, PCin, IncPC, IRin, MARin, MDRin, MDRout, Read, Write} = '0;
        {Gra, Grb, Grc, Rin, Rout, BAout} = '0;
        {Yin, Zin, Zhighout, Zlowout, Cout, CONin} = '0;
        {HIin, HIout, LOin, LOout, illegal} = '0;
        ALUselect = '0;
        run = (state != ST_RESET) && (state != ST_HALT);
        case (state)
            ST_T0: begin PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; end
            ST_T1: begin Read = 1'b1; MDRin = 1'b1; end
            ST_T2: begin MDRout = 1'b1; IRin = 1'b1; end
            ST_T3: begin
                case (op_class)
                    CL_ALU, CL_IMM:      begin Grb = 1'b1; Rout = 1'b1; Yin = 1'b1; end
                    CL_LDI, CL_LD, CL_ST: begin Grb = 1'b1; BAout = 1'b1; Yin = 1'b1; end
                    CL_MULDIV:           begin Gra = 1'b1; Rout = 1'b1; Yin = 1'b1; end
                    CL_MFHI:             begin HIout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                    CL_MFLO:             begin LOout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                    CL_BR:               begin Gra = 1'b1; Rout = 1'b1; CONin = 1'b1; end
                    CL_ILLEGAL:          illegal = 1'b1;
                    default: ;
                endcase
            end
            ST_T4: begin
                case (op_class)
                    CL_ALU:    begin Grc = 1'b1; Rout = 1'b1; Zin = 1'b1; ALUselect = SEL_W'(alu_code); end
                    CL_IMM, CL_LDI, CL_LD, CL_ST:
                               begin Cout = 1'b1; Zin = 1'b1; ALUselect = SEL_W'(alu_code); end
                    CL_MULDIV: begin Grb = 1'b1; Rout = 1'b1; Zin = 1'b1; ALUselect = SEL_W'(alu_code); end
                    CL_BR:     begin PCout = 1'b1; Yin = 1'b1; end
                    default: ;
                endcase
            end
            ST_T5: begin
                case (op_class)
                    CL_ALU, CL_IMM, CL_LDI: begin Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                    CL_LD, CL_ST:           begin Zlowout = 1'b1; MARin = 1'b1; end
                    CL_MULDIV:              begin Zlowout = 1'b1; LOin = 1'b1; end
                    CL_BR:                  begin Cout = 1'b1; Zin = 1'b1; ALUselect = SEL_W'(alu_code); end
                    default: ;
                endcase
            end
            ST_T6: begin
                case (op_class)
                    CL_LD:     begin Read = 1'b1; MDRin = 1'b1; end
                    CL_ST:     begin Gra = 1'b1; Rout = 1'b1; MDRin = 1'b1; end
                    CL_MULDIV: begin Zhighout = 1'b1; HIin = 1'b1; end
                    CL_BR:     begin Zlowout = 1'b1; PCin = con_ff; end
                    default: ;
                endcase
            end
            ST_T7: begin
                case (op_class)
                    CL_LD:   begin MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                    CL_ST:   Write = 1'b1;
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_control_sequencer.sv
// Self-checking bench for control_sequencer: latency/decode table, directed
// corner sequences and random instructions checked against a step-list model.
module tb_control_sequencer;

    typedef logic [30:0] cw_t;

    localparam cw_t M_PCOUT   = cw_t'(1) << 0;
    localparam cw_t M_PCIN    = cw_t'(1) << 1;
    localparam cw_t M_INCPC   = cw_t'(1) << 2;
    localparam cw_t M_IRIN    = cw_t'(1) << 3;
    localparam cw_t M_MARIN   = cw_t'(1) << 4;
    localparam cw_t M_MDRIN   = cw_t'(1) << 5;
    localparam cw_t M_MDROUT  = cw_t'(1) << 6;
    localparam cw_t M_READ    = cw_t'(1) << 7;
    localparam cw_t M_WRITE   = cw_t'(1) << 8;
    localparam cw_t M_GRA     = cw_t'(1) << 9;
    localparam cw_t M_GRB     = cw_t'(1) << 10;
    localparam cw_t M_GRC     = cw_t'(1) << 11;
    localparam cw_t M_RIN     = cw_t'(1) << 12;
    localparam cw_t M_ROUT    = cw_t'(1) << 13;
    localparam cw_t M_BAOUT   = cw_t'(1) << 14;
    localparam cw_t M_YIN     = cw_t'(1) << 15;
    localparam cw_t M_ZIN     = cw_t'(1) << 16;
    localparam cw_t M_ZHIGH   = cw_t'(1) << 17;
    localparam cw_t M_ZLOW    = cw_t'(1) << 18;
    localparam cw_t M_COUT    = cw_t'(1) << 19;
    localparam cw_t M_CONIN   = cw_t'(1) << 20;
    localparam cw_t M_HIIN    = cw_t'(1) << 21;
    localparam cw_t M_HIOUT   = cw_t'(1) << 22;
    localparam cw_t M_LOIN    = cw_t'(1) << 23;
    localparam cw_t M_LOOUT   = cw_t'(1) << 24;
    localparam cw_t M_ILLEGAL = cw_t'(1) << 25;
    localparam cw_t M_RUN     = cw_t'(1) << 26;
    localparam cw_t T0_WORD   = M_RUN | M_PCOUT | M_MARIN | M_INCPC;

    logic        clock = 1'b0;
    logic        clear = 1'b0;
    logic [31:0] ir = '0;
    logic        con_ff = 1'b0;
    logic        stop = 1'b0;
    logic PCout, PCin, IncPC, IRin, MARin, MDRin, MDRout, Read, Write;
    logic Gra, Grb, Grc, Rin, Rout, BAout, Yin, Zin, Zhighout, Zlowout, Cout, CONin;
    logic HIin, HIout, LOin, LOout, run, illegal;
    logic [3:0] ALUselect;

    int checks = 0;
    int fails  = 0;
    cw_t exp_q[$];

    typedef struct {
        string      name;
        logic [4:0] op;
        logic       c;
        int         cycles;
        cw_t        t3;
    } vec_t;
    vec_t vecs[12];

    control_sequencer #(.IR_W(32), .SEL_W(4)) dut (
        .clock(clock), .clear(clear), .ir(ir), .con_ff(con_ff), .stop(stop),
        .PCout(PCout), .PCin(PCin), .IncPC(IncPC), .IRin(IRin), .MARin(MARin),
        .MDRin(MDRin), .MDRout(MDRout), .Read(Read), .Write(Write),
        .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout), .BAout(BAout),
        .Yin(Yin), .Zin(Zin), .Zhighout(Zhighout), .Zlowout(Zlowout), .Cout(Cout),
        .CONin(CONin), .HIin(HIin), .HIout(HIout), .LOin(LOin), .LOout(LOout),
        .ALUselect(ALUselect), .run(run), .illegal(illegal)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected $finish");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic cw_t pack_outputs();
        return {ALUselect, run, illegal, LOout, LOin, HIout, HIin, CONin, Cout,
                Zlowout, Zhighout, Zin, Yin, BAout, Rout, Rin, Grc, Grb, Gra,
                Write, Read, MDRout, MDRin, MARin, IRin, IncPC, PCin, PCout};
    endfunction

    function automatic cw_t alu(input int code);
        return cw_t'(code) << 27;
    endfunction

    function automatic int alu_of(input logic [4:0] op);
        case (op)
            5'b00100:           return 1;
            5'b01010, 5'b01101: return 2;
            5'b01011, 5'b01110: return 3;
            5'b01111:           return 9;
            5'b10000:           return 10;
            default:            return 0;
        endcase
    endfunction

    // Reference model: the list of control words one instruction must produce, step by step.
    task automatic build_seq(input logic [4:0] op, input logic c, output bit ends_halt);
        exp_q.delete();
        ends_halt = 1'b0;
        exp_q.push_back(M_PCOUT | M_MARIN | M_INCPC);
        exp_q.push_back(M_READ | M_MDRIN);
        exp_q.push_back(M_MDROUT | M_IRIN);
        case (op)
            5'b00011, 5'b00100, 5'b01010, 5'b01011: begin
                exp_q.push_back(M_GRB | M_ROUT | M_YIN);
                exp_q.push_back(M_GRC | M_ROUT | M_ZIN | alu(alu_of(op)));
                exp_q.push_back(M_ZLOW | M_GRA | M_RIN);
            end
            5'b01100, 5'b01101, 5'b01110: begin
                exp_q.push_back(M_GRB | M_ROUT | M_YIN);
                exp_q.push_back(M_COUT | M_ZIN | alu(alu_of(op)));
                exp_q.push_back(M_ZLOW | M_GRA | M_RIN);
            end
            5'b00001, 5'b00000, 5'b00010: begin
                exp_q.push_back(M_GRB | M_BAOUT | M_YIN);
                exp_q.push_back(M_COUT | M_ZIN | alu(0));
                if (op == 5'b00001) begin
                    exp_q.push_back(M_ZLOW | M_GRA | M_RIN);
                end else begin
                    exp_q.push_back(M_ZLOW | M_MARIN);
                    if (op == 5'b00000) begin
                        exp_q.push_back(M_READ | M_MDRIN);
                        exp_q.push_back(M_MDROUT | M_GRA | M_RIN);
                    end else begin
                        exp_q.push_back(M_GRA | M_ROUT | M_MDRIN);
                        exp_q.push_back(M_WRITE);
                    end
                end
            end
            5'b01111, 5'b10000: begin
                exp_q.push_back(M_GRA | M_ROUT | M_YIN);
                exp_q.push_back(M_GRB | M_ROUT | M_ZIN | alu(alu_of(op)));
                exp_q.push_back(M_ZLOW | M_LOIN);
                exp_q.push_back(M_ZHIGH | M_HIIN);
            end
            5'b10011: begin
                exp_q.push_back(M_GRA | M_ROUT | M_CONIN);
                exp_q.push_back(M_PCOUT | M_YIN);
                exp_q.push_back(M_COUT | M_ZIN | alu(0));
                exp_q.push_back(M_ZLOW | (c ? M_PCIN : cw_t'(0)));
            end
            5'b11000: exp_q.push_back(M_HIOUT | M_GRA | M_RIN);
            5'b11001: exp_q.push_back(M_LOOUT | M_GRA | M_RIN);
            5'b11010: exp_q.push_back(cw_t'(0));
            5'b11011: begin exp_q.push_back(cw_t'(0)); ends_halt = 1'b1; end
            default:  exp_q.push_back(M_ILLEGAL);
        endcase
        foreach (exp_q[i]) exp_q[i] = exp_q[i] | M_RUN;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] expv);
        checks++;
        if (got !== expv) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, got, expv);
        end
    endtask

    task automatic do_reset(input string tag);
        clear = 1'b0;
        @(negedge clock);
        checkOutput({tag, " reset outputs"}, pack_outputs(), 0);
        clear = 1'b1;
        @(negedge clock);
        checkOutput({tag, " first T0"}, pack_outputs(), T0_WORD);
    endtask

    // Runs one instruction from T0; stop is held high during step stop_at (-1 for none).
    task automatic run_instr(input logic [31:0] instr, input logic c, input int stop_at, input string tag);
        bit halt_exp;
        build_seq(instr[31:27], c, halt_exp);
        if (stop_at >= 0) halt_exp = 1'b1;
        ir = instr;
        con_ff = c;
        for (int i = 0; i < exp_q.size(); i++) begin
            stop = (i == stop_at);
            checkOutput($sformatf("%s step %0d", tag, i), pack_outputs(), exp_q[i]);
            @(negedge clock);
            if (i == 3) ir = $urandom;
        end
        stop = 1'b0;
        if (halt_exp) begin
            for (int k = 0; k < 3; k++) begin
                checkOutput($sformatf("%s halted %0d", tag, k), pack_outputs(), 0);
                @(negedge clock);
            end
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        int  cycles;
        cw_t t3;
        ir = {v.op, 27'($urandom)};
        con_ff = v.c;
        cycles = 0;
        t3 = '0;
        for (int n = 0; n < 12; n++) begin
            if (n == 3) t3 = pack_outputs();
            @(negedge clock);
            cycles++;
            if (pack_outputs() == T0_WORD) break;
        end
        checkOutput({v.name, " T3 word"}, t3, v.t3 | M_RUN);
        checkOutput({v.name, " latency"}, cycles, v.cycles);
    endtask

    initial begin
        logic [4:0] op;
        int         stop_at;

        vecs[0]  = '{"add",     5'b00011, 1'b0, 6, M_GRB | M_ROUT | M_YIN};
        vecs[1]  = '{"ori",     5'b01110, 1'b0, 6, M_GRB | M_ROUT | M_YIN};
        vecs[2]  = '{"ldi",     5'b00001, 1'b0, 6, M_GRB | M_BAOUT | M_YIN};
        vecs[3]  = '{"ld",      5'b00000, 1'b0, 8, M_GRB | M_BAOUT | M_YIN};
        vecs[4]  = '{"st",      5'b00010, 1'b0, 8, M_GRB | M_BAOUT | M_YIN};
        vecs[5]  = '{"mul",     5'b01111, 1'b0, 7, M_GRA | M_ROUT | M_YIN};
        vecs[6]  = '{"div",     5'b10000, 1'b1, 7, M_GRA | M_ROUT | M_YIN};
        vecs[7]  = '{"br",      5'b10011, 1'b1, 7, M_GRA | M_ROUT | M_CONIN};
        vecs[8]  = '{"mfhi",    5'b11000, 1'b0, 4, M_HIOUT | M_GRA | M_RIN};
        vecs[9]  = '{"mflo",    5'b11001, 1'b0, 4, M_LOOUT | M_GRA | M_RIN};
        vecs[10] = '{"nop",     5'b11010, 1'b0, 4, cw_t'(0)};
        vecs[11] = '{"illegal", 5'b10110, 1'b0, 4, M_ILLEGAL};

        do_reset("power-up");

        foreach (vecs[i]) applyStimulus(vecs[i]);

        run_instr(32'h18918000, 1'b0, -1, "add R1,R2,R3");
        run_instr({5'b00010, 27'h0123456}, 1'b0, -1, "st");
        run_instr({5'b10011, 27'h0000040}, 1'b0, -1, "br con0");
        run_instr({5'b10011, 27'h0000040}, 1'b1, -1, "br con1");
        run_instr({5'b11111, 27'h0}, 1'b0, -1, "opcode 11111");

        // Stop seen in T1, then a clear in T4 must abandon the add and forget the stop.
        ir = 32'h18918000;
        @(negedge clock);
        stop = 1'b1;
        @(negedge clock);
        stop = 1'b0;
        @(negedge clock);
        @(negedge clock);
        checkOutput("add T4 before clear", pack_outputs(), M_RUN | M_GRC | M_ROUT | M_ZIN | alu(0));
        do_reset("mid-add clear");
        run_instr({5'b11010, 27'h0}, 1'b0, -1, "nop after clear");
        checkOutput("stop flag cleared by clear", pack_outputs(), T0_WORD);

        run_instr({5'b01111, 27'h0ABCDEF}, 1'b0, 4, "mul stop@T4");
        do_reset("after mul halt");
        run_instr({5'b11010, 27'h0}, 1'b0, 3, "nop stop@last");
        do_reset("after nop halt");
        run_instr({5'b11011, 27'h0}, 1'b0, -1, "halt opcode");
        do_reset("after halt opcode");

        for (int n = 0; n < 40; n++) begin
            op = 5'($urandom_range(0, 31));
            if (op == 5'b11011) op = 5'b11010;
            stop_at = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 3)) : -1;
            run_instr({op, 27'($urandom)}, 1'($urandom_range(0, 1)), stop_at,
                      $sformatf("rand%0d op=%05b", n, op));
            if (stop_at >= 0) do_reset($sformatf("rand%0d", n));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
